// File: rtl/add_n_arbiter.sv
// Round-robin front end that time-shares one external NUM_ELEMS-input adder between
// NUM_REQ requesters; one operation in flight, each sum returned tagged with its requester id.
module add_n_arbiter #(
  parameter int DATA_WIDTH = 2,
  parameter int NUM_ELEMS  = 2,
  parameter int NUM_REQ    = 4,
  parameter int ADD_LAT    = 1,
  localparam int ID_W      = ($clog2(NUM_REQ) > 1) ? $clog2(NUM_REQ) : 1,
  localparam int SLICE_W   = NUM_ELEMS * DATA_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*SLICE_W-1:0] req_data,
  output logic [SLICE_W-1:0]         add_inps,
  input  logic [DATA_WIDTH-1:0]      add_outp,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [DATA_WIDTH-1:0]      rsp_data,
  output logic [ID_W-1:0]            rsp_id
);

  localparam int CNT_W = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ID_W-1:0]       ptr_q, ptr_d;
  logic [SLICE_W-1:0]    add_inps_q, add_inps_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [ID_W-1:0]       rsp_id_q, rsp_id_d;

  logic                  grant_found;
  logic [ID_W-1:0]       grant_idx;
  logic [ID_W-1:0]       cand;

  // Search starts one past the last winner so every valid requester is reached within NUM_REQ grants.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = ID_W'((int'(ptr_q) + k) % NUM_REQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Gated by rst_n so no grant is visible while reset is held.
  always_comb begin
    req_ready = '0;
    if (rst_n && (state_q == IDLE) && grant_found) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    add_inps_d  = add_inps_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    unique case (state_q)
      IDLE: begin
        if (grant_found) begin
          add_inps_d = req_data[int'(grant_idx)*SLICE_W +: SLICE_W];
          rsp_id_d   = grant_idx;
          ptr_d      = grant_idx;
          cnt_d      = CNT_W'(ADD_LAT - 1);
          state_d    = BUSY;
        end
      end
      BUSY: begin
        // Sum is sampled exactly ADD_LAT edges after the operands were registered.
        if (cnt_q == '0) begin
          rsp_data_d  = add_outp;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ptr_q       <= ID_W'(NUM_REQ - 1);
      add_inps_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      add_inps_q  <= add_inps_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

  assign add_inps  = add_inps_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_add_n_arbiter.sv
// Bench for add_n_arbiter: one instance with a combinational adder (ADD_LAT=1) and one with a
// two-register adder (ADD_LAT=3), exercised in turn against a timestamped scoreboard.
module tb_add_n_arbiter;

  localparam int DW  = 2;
  localparam int NE  = 2;
  localparam int NR  = 4;
  localparam int IDW = 2;
  localparam int SW  = NE * DW;
  localparam logic [DW-1:0] ONE_C = 1;

  typedef struct {
    int id;
    int sum;
    int vfrom;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sel = 1'b0;
  always #5 clk = ~clk;

  logic [NR-1:0] rv = '0;
  logic          rr = 1'b1;
  logic [DW-1:0] rd [NR][NE];
  logic [NR*SW-1:0] req_data_v;

  always_comb begin
    req_data_v = '0;
    for (int r = 0; r < NR; r++)
      for (int e = 0; e < NE; e++)
        req_data_v[(r*NE+e)*DW +: DW] = rd[r][e];
  end

  logic [NR-1:0]  rv1, rv3, rdy1, rdy3, rdy;
  logic           rr1, rr3, v1, v3, rsp_v;
  logic [SW-1:0]  ai1, ai3, ai;
  logic [DW-1:0]  ao1, ao3, d1, d3, rsp_d;
  logic [IDW-1:0] id1, id3, rsp_i;

  assign rv1   = sel ? '0 : rv;
  assign rv3   = sel ? rv : '0;
  assign rr1   = sel ? 1'b0 : rr;
  assign rr3   = sel ? rr : 1'b0;
  assign rdy   = sel ? rdy3 : rdy1;
  assign ai    = sel ? ai3 : ai1;
  assign rsp_v = sel ? v3 : v1;
  assign rsp_d = sel ? d3 : d1;
  assign rsp_i = sel ? id3 : id1;

  add_n_arbiter #(.DATA_WIDTH(DW), .NUM_ELEMS(NE), .NUM_REQ(NR), .ADD_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(rv1), .req_ready(rdy1), .req_data(req_data_v),
    .add_inps(ai1), .add_outp(ao1), .rsp_valid(v1), .rsp_ready(rr1), .rsp_data(d1), .rsp_id(id1));

  add_n_arbiter #(.DATA_WIDTH(DW), .NUM_ELEMS(NE), .NUM_REQ(NR), .ADD_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(rv3), .req_ready(rdy3), .req_data(req_data_v),
    .add_inps(ai3), .add_outp(ao3), .rsp_valid(v3), .rsp_ready(rr3), .rsp_data(d3), .rsp_id(id3));

  function automatic logic [DW-1:0] vsum(input logic [SW-1:0] v);
    logic [DW-1:0] s;
    s = '0;
    for (int i = 0; i < NE; i++) s = s + v[i*DW +: DW];
    return s;
  endfunction

  // External adders: combinational for dut1; two-stage pipeline for dut3 that shows a wrong
  // value until the operands have been stable long enough for the pipeline to hold their sum.
  assign ao1 = vsum(ai1);
  logic [SW-1:0] i1 = '0, i2 = '0;
  logic [DW-1:0] s1 = '0, s2 = '0;
  always @(posedge clk) begin
    i1 <= ai3;
    i2 <= i1;
    s1 <= vsum(ai3);
    s2 <= s1;
  end
  assign ao3 = (i2 == ai3) ? s2 : vsum(ai3) + ONE_C;

  int   n_cmp = 0, n_bad = 0;
  int   cyc = 0;
  int   ptr_m = NR - 1;
  int   idle_from = 0;
  int   served = -1;
  int   lat = 1;
  bit   keep = 1'b0, auto_on = 1'b0;
  exp_t sb[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (lat=%0d t=%0t)", nm, act, exp, lat, $time);
    end
  endtask

  // Monitor: response side, driven only by the scoreboard's timestamps.
  always @(negedge clk) begin
    bit ev;
    ev = 1'b0;
    if (sb.size() > 0) ev = (cyc >= sb[0].vfrom);
    check("rsp_valid", 32'(rsp_v), 32'(ev));
    if (ev) begin
      check("rsp_data", 32'(rsp_d), 32'(sb[0].sum));
      check("rsp_id", 32'(rsp_i), 32'(sb[0].id));
      if (rr) begin
        void'(sb.pop_front());
        idle_from = cyc + 1;
      end
    end
  end

  task automatic new_data(input int r);
    for (int e = 0; e < NE; e++) rd[r][e] = DW'($urandom);
  endtask

  task automatic drive_begin();
    @(posedge clk);
    #1;
    if (served >= 0) begin
      if (keep) new_data(served);
      else rv = rv & ~(NR'(1) << served);
      served = -1;
    end
    if (auto_on) begin
      for (int r = 0; r < NR; r++) begin
        if (((rv >> r) & NR'(1)) == '0) begin
          if ($urandom_range(3) == 0) begin
            new_data(r);
            rv = rv | (NR'(1) << r);
          end
        end else if ($urandom_range(9) == 0) begin
          rv = rv & ~(NR'(1) << r);
        end
      end
      rr = ($urandom_range(3) != 0);
    end
  endtask

  // Request-side model: round-robin from the last winner, only when no op is outstanding.
  task automatic cycle_end();
    logic [NR-1:0] er;
    int g, sum;
    exp_t e;
    @(negedge clk);
    #1;
    er = '0;
    g  = -1;
    if (rst_n && sb.size() == 0 && cyc >= idle_from) begin
      for (int k = 1; k <= NR; k++) begin
        int r;
        r = (ptr_m + k) % NR;
        if (g < 0 && ((rv >> r) & NR'(1)) != '0) g = r;
      end
    end
    if (g >= 0) er = NR'(1) << g;
    check("req_ready", 32'(rdy), 32'(er));
    if (g >= 0) begin
      sum = 0;
      for (int k = 0; k < NE; k++) sum += int'(rd[g][k]);
      e.id    = g;
      e.sum   = sum % (1 << DW);
      e.vfrom = cyc + lat + 1;
      sb.push_back(e);
      ptr_m  = g;
      served = g;
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      drive_begin();
      cycle_end();
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    check({tag, "_req_ready"}, 32'(rdy), 32'(0));
    check({tag, "_add_inps"}, 32'(ai), 32'(0));
    check({tag, "_rsp_valid"}, 32'(rsp_v), 32'(0));
    check({tag, "_rsp_data"}, 32'(rsp_d), 32'(0));
    check({tag, "_rsp_id"}, 32'(rsp_i), 32'(0));
  endtask

  task automatic model_reset();
    sb.delete();
    ptr_m     = NR - 1;
    idle_from = 0;
    served    = -1;
  endtask

  task automatic drain();
    auto_on = 1'b0;
    keep    = 1'b0;
    rr      = 1'b1;
    drive_begin();
    rv = '0;
    cycle_end();
    step(3 * (lat + 2));
  endtask

  initial begin
    for (int r = 0; r < NR; r++)
      for (int e = 0; e < NE; e++) rd[r][e] = '0;

    for (int pass = 0; pass < 2; pass++) begin
      // Reset with every requester asserting: no grant may leak out while reset is held.
      drive_begin();
      rst_n = 1'b0;
      sel   = pass[0];
      lat   = (pass == 0) ? 1 : 3;
      model_reset();
      auto_on = 1'b0;
      keep    = 1'b0;
      rr      = 1'b1;
      rv      = '1;
      #1;
      chk_zero_outputs("reset");
      cycle_end();
      drive_begin();
      rv = '0;
      cycle_end();
      drive_begin();
      rst_n = 1'b1;
      cycle_end();

      // All requesters continuously valid, consumer always ready.
      drive_begin();
      keep = 1'b1;
      for (int r = 0; r < NR; r++) new_data(r);
      rv = '1;
      cycle_end();
      step(6 * (lat + 2));
      drain();

      // Single requester 1 with elements {3,2}: sum wraps to 1.
      drive_begin();
      rd[1][0] = 2'd3;
      rd[1][1] = 2'd2;
      rv = 4'b0010;
      cycle_end();
      step(lat + 4);
      drain();

      // Consumer stalls for several cycles while all requesters wait.
      drive_begin();
      keep = 1'b1;
      for (int r = 0; r < NR; r++) new_data(r);
      rv = '1;
      rr = 1'b0;
      cycle_end();
      step(lat + 7);
      drive_begin();
      rr = 1'b1;
      cycle_end();
      step(2 * (lat + 2));
      drain();

      // Requester 3 raises then withdraws while requester 0 is being served.
      drive_begin();
      new_data(0);
      rv = 4'b0001;
      cycle_end();
      drive_begin();
      new_data(2);
      new_data(3);
      rv = 4'b1100;
      cycle_end();
      drive_begin();
      rv = 4'b0100;
      cycle_end();
      step(2 * (lat + 2));
      drain();

      // Reset while the operation is in flight: it is dropped, then requester 0 wins first.
      drive_begin();
      rd[0][0] = 2'd1;
      rd[0][1] = 2'd2;
      rv = 4'b0001;
      cycle_end();
      drive_begin();
      rst_n = 1'b0;
      model_reset();
      rv = 4'b0101;
      new_data(2);
      #1;
      chk_zero_outputs("midrst");
      cycle_end();
      step(2);
      drive_begin();
      rst_n = 1'b1;
      cycle_end();
      step(2 * (lat + 2));
      drain();

      // Randomised traffic and back-pressure.
      auto_on = 1'b1;
      step(400);
      drain();
      step(lat + 4);
      check("scoreboard_empty", 32'(sb.size()), 32'(0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
